// File: rtl/color_request_arbiter_if.sv
// ----------------------------------------------------------------------------
// color_request_arbiter_if
//
// Bundles the request side, credit input, memory side and tracker push of the
// color request arbiter.
//
//   req_valid    [COLORS]            per-color request pending
//   req_addr     [COLORS*ADDR_WIDTH] color i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ack      [COLORS]            one-hot, request of color i consumed this cycle
//   credit_ready                     tracker has room for another request
//   mem_valid / mem_addr / mem_tag   registered request toward memory
//   mem_stall                        memory cannot accept the held request
//   push / push_tag                  tracker increment on memory handshake
//
// Modports:
//   master - the arbiter
//   slave  - requesters, tracker and memory as seen by the arbiter
// ----------------------------------------------------------------------------
interface color_request_arbiter_if #(
    parameter int COLORS     = 4,
    parameter int ADDR_WIDTH = 48
);
    localparam int LOG2_COLORS = $clog2(COLORS);

    logic [COLORS-1:0]            req_valid;
    logic [COLORS*ADDR_WIDTH-1:0] req_addr;
    logic [COLORS-1:0]            req_ack;
    logic                         credit_ready;
    logic                         mem_valid;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [LOG2_COLORS-1:0]       mem_tag;
    logic                         mem_stall;
    logic                         push;
    logic [LOG2_COLORS-1:0]       push_tag;

    modport master (
        input  req_valid, req_addr, credit_ready, mem_stall,
        output req_ack, mem_valid, mem_addr, mem_tag, push, push_tag
    );

    modport slave (
        output req_valid, req_addr, credit_ready, mem_stall,
        input  req_ack, mem_valid, mem_addr, mem_tag, push, push_tag
    );
endinterface

// File: rtl/color_request_arbiter.sv
// ----------------------------------------------------------------------------
// color_request_arbiter
//
// Round-robin arbiter in front of the in-flight tracker. Picks one of COLORS
// requesters per cycle when the output slot is free and the tracker grants
// credit, holds the winner in a one-entry output register toward memory, and
// pushes the tag into the tracker on every accepted memory handshake.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - color_request_arbiter_if.master (request, credit, memory, push)
//
// Build option:
//   COLOR_ARB_FIXED_PRIORITY_EN - when defined, the lowest-numbered valid
//   color always wins and the round-robin pointer is tied to zero.
// ----------------------------------------------------------------------------
module color_request_arbiter #(
    parameter int COLORS     = 4,
    parameter int ADDR_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    color_request_arbiter_if.master bus
);
    localparam int LOG2_COLORS = $clog2(COLORS);

    typedef logic [LOG2_COLORS-1:0] tag_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    localparam tag_t LAST_COLOR = tag_t'(COLORS - 1);

    logic        mem_valid_q;
    addr_t       mem_addr_q;
    tag_t        mem_tag_q;
    tag_t        ptr;

    logic        slot_free;
    logic        grant;
    tag_t        winner;
    addr_t       winner_addr;
    logic        found_hi;
    tag_t        win_hi;
    tag_t        win_lo;
    logic [COLORS-1:0] ack;

    // The slot frees either because it is empty or because its occupant
    // leaves on this edge, which lets a new grant refill it back to back.
    assign slot_free = !mem_valid_q || !bus.mem_stall;
    assign grant     = !rst && slot_free && bus.credit_ready && (|bus.req_valid);

    // Winner search: scanning from the top down leaves win_lo at the lowest
    // valid color overall and win_hi at the lowest valid color at or above
    // ptr. A hit at or above ptr wins; otherwise the scan wrapped to win_lo.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        found_hi    = 1'b0;
        win_hi      = '0;
        win_lo      = '0;
        winner_addr = '0;
        ack         = '0;
        for (int i = COLORS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (i >= int'(ptr)) begin
                    win_hi   = tag_t'(i);
                    found_hi = 1'b1;
                end
                win_lo = tag_t'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
        for (int i = 0; i < COLORS; i++) begin
            if (tag_t'(i) == winner) begin
                winner_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                if (grant) ack[i] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_tag_q   <= '0;
        end else if (grant) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= winner_addr;
            mem_tag_q   <= winner;
        end else if (slot_free) begin
            // Drained with nothing to refill: address and tag hold.
            mem_valid_q <= 1'b0;
        end
    end

`ifdef COLOR_ARB_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            // Explicit wrap so non-power-of-two COLORS never points past the end.
            ptr <= (winner == LAST_COLOR) ? '0 : winner + tag_t'(1);
        end
    end
`endif

    assign bus.req_ack   = ack;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_tag   = mem_tag_q;
    // A request held while rst is high is discarded on the reset edge, so it
    // must not be counted by the tracker.
    assign bus.push      = !rst && mem_valid_q && !bus.mem_stall;
    assign bus.push_tag  = mem_tag_q;

endmodule

// File: doc/color_request_arbiter.md
# color_request_arbiter

Round-robin arbiter sitting directly upstream of the in-flight tracker. Selects one of COLORS tagged memory requesters per cycle, gated by the tracker's `ready` credit, and holds the winner in a one-entry output register toward the memory interface. On each accepted memory handshake it emits `push`/`push_tag` into the tracker so outstanding-request counts stay exact.

## Interface
- COLORS, 4, number of requester colors (tags); any value ≥ 2.
- ADDR_WIDTH, 48, request address width.
- LOG2_COLORS, log2(COLORS), derived (localparam), tag width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  COLORS  per-color request pending; bit i = color i.
- req_addr  in  COLORS*ADDR_WIDTH  color i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ack  out  COLORS  one-hot, combinational; request of color i consumed this cycle.
- credit_ready  in  1  tracker `ready`; low blocks new grants.
- mem_valid  out  1  registered request valid toward memory.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_tag  out  LOG2_COLORS  registered color of held request.
- mem_stall  in  1  memory cannot accept; request held.
- push  out  1  combinational; = mem_valid && !mem_stall.
- push_tag  out  LOG2_COLORS  = mem_tag.

## Operation
- State: output register {mem_valid, mem_addr, mem_tag}; round-robin pointer `ptr` (LOG2_COLORS bits, range 0..COLORS-1).
- `slot_free` = !mem_valid || !mem_stall.
- Grant condition: slot_free && credit_ready && |req_valid.
- Winner: first color with req_valid set, scanning ptr, ptr+1, …, wrapping at COLORS-1 to 0.
- On grant: req_ack[winner]=1; next edge loads mem_addr=req_addr[winner], mem_tag=winner, mem_valid=1; ptr ← winner+1 (wraps to 0 after COLORS-1).
- No grant and slot_free: mem_valid ← 0; mem_addr/mem_tag hold.
- mem_valid && mem_stall: all output registers hold; req_ack=0; ptr holds.
- push fires exactly once per request leaving the block; never for a dropped request.
- Requester contract: req_valid/req_addr stable until req_ack; arbiter does not check.

## Timing
- Reset values: mem_valid=0, mem_addr=0, mem_tag=0, ptr=0; hence push=0, push_tag=0; req_ack=0 while rst high.
- Latency: req_ack in cycle t → mem_valid in cycle t+1. Min request-to-memory latency 1 cycle.
- Throughput: 1 request/cycle with mem_stall low and credit_ready high (drain and refill same edge).
- credit_ready low: no new grant; held request still drains and pushes. Tracker sees push one cycle after ack at the earliest, so credit_ready is sampled before the increment; tracker headroom must absorb one extra in-flight request.
- Single requester: granted every cycle; ptr wraps correctly for non-power-of-two COLORS.
- rst asserted mid-operation: held request discarded on next edge, no push, ptr → 0; req_ack forced 0 during rst.

## Configuration
- `COLOR_ARB_FIXED_PRIORITY_EN` defined: fixed priority, lowest-numbered valid color wins; ptr not implemented (or tied 0).
- Not defined: round-robin as described above (default).

## Test plan
- Reset: assert rst 2 cycles with req_valid=4'b1111 → req_ack=0, mem_valid=0, push=0, mem_tag=0 throughout and first cycle after.
- Round-robin: req_valid=4'b1111 held, credit_ready=1, mem_stall=0 → mem_tag sequence 0,1,2,3,0,… one per cycle; push every cycle with matching push_tag.
- Stall: grant color 2, raise mem_stall 3 cycles → mem_valid=1, mem_tag=2, mem_addr stable, req_ack=0, push=0 for 3 cycles; single push with push_tag=2 on release.
- Credit gate: credit_ready=0 with req_valid=4'b0101 → no req_ack, mem_valid falls after held request drains; credit_ready=1 → color 0 granted then color 2.
- Skip and wrap: ptr=3, req_valid=4'b0010 → color 1 granted, ptr becomes 2; COLORS=3 build, all valid → tags 0,1,2,0.
- Macro: with `COLOR_ARB_FIXED_PRIORITY_EN`, req_valid=4'b0110 held → color 1 granted every cycle, color 2 never.
